// File: rtl/i2c_eeprom_slave.sv
// I2C responder modelling a 24-series EEPROM with 16-bit word addressing.
// Supports byte/sequential write, random, current-address and sequential read.
module i2c_eeprom_slave #(
    parameter logic [6:0]  DEV_ADDR = 7'b1010_000,
    parameter int unsigned MEM_AW   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        busy,
    output logic        wr_pulse,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_byte
);

    localparam int unsigned DEPTH = 1 << MEM_AW;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEV_ADDR,
        S_ACK_DEV,
        S_ADDR_HI,
        S_ACK_HI,
        S_ADDR_LO,
        S_ACK_LO,
        S_WR_DATA,
        S_ACK_WR,
        S_RD_DATA,
        S_RD_ACK
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [7:0]  sr, sr_nxt;
    logic        ack_hold, ack_hold_nxt;
    logic        rw, rw_nxt;
    logic [7:0]  addr_hi, addr_hi_nxt;
    logic [15:0] ptr, ptr_nxt;
    logic        sda_oe_nxt;
    logic        busy_nxt;
    logic        wr_pulse_nxt;
    logic [15:0] wr_addr_nxt;
    logic [7:0]  wr_byte_nxt;
    logic        mem_we;

    logic scl_meta, scl_sync, scl_hist;
    logic sda_meta, sda_sync, sda_hist;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [7:0]  mem [DEPTH];
    logic [7:0]  rx_byte;
    logic [7:0]  rd_cur, rd_next;
    logic [15:0] ptr_inc;

    // Synchronizers reset to the idle-bus level so reset release never fakes a START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_hist <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_meta <= scl;
            scl_sync <= scl_meta;
            scl_hist <= scl_sync;
            sda_meta <= sda_in;
            sda_sync <= sda_meta;
            sda_hist <= sda_sync;
        end
    end

    assign scl_rise  = scl_sync & ~scl_hist;
    assign scl_fall  = ~scl_sync & scl_hist;
    assign start_det = scl_sync & scl_hist & sda_hist & ~sda_sync;
    assign stop_det  = scl_sync & scl_hist & ~sda_hist & sda_sync;

    assign rx_byte = {sr[6:0], sda_sync};
    assign ptr_inc = ptr + 16'd1;
    assign rd_cur  = mem[ptr[MEM_AW-1:0]];
    assign rd_next = mem[ptr_inc[MEM_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sr       <= '0;
            ack_hold <= 1'b0;
            rw       <= 1'b0;
            addr_hi  <= '0;
            ptr      <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            wr_byte  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sr       <= sr_nxt;
            ack_hold <= ack_hold_nxt;
            rw       <= rw_nxt;
            addr_hi  <= addr_hi_nxt;
            ptr      <= ptr_nxt;
            sda_oe   <= sda_oe_nxt;
            busy     <= busy_nxt;
            wr_pulse <= wr_pulse_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_byte  <= wr_byte_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr[MEM_AW-1:0]] <= rx_byte;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        sr_nxt       = sr;
        ack_hold_nxt = ack_hold;
        rw_nxt       = rw;
        addr_hi_nxt  = addr_hi;
        ptr_nxt      = ptr;
        sda_oe_nxt   = sda_oe;
        busy_nxt     = busy;
        wr_pulse_nxt = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_byte_nxt  = wr_byte;
        mem_we       = 1'b0;

        if (stop_det) begin
            state_nxt    = S_IDLE;
            sda_oe_nxt   = 1'b0;
            busy_nxt     = 1'b0;
            ack_hold_nxt = 1'b0;
        end else if (start_det) begin
            state_nxt    = S_DEV_ADDR;
            cnt_nxt      = '0;
            sda_oe_nxt   = 1'b0;
            busy_nxt     = 1'b1;
            ack_hold_nxt = 1'b0;
        end else begin
            case (state)
                S_DEV_ADDR, S_ADDR_HI, S_ADDR_LO, S_WR_DATA: begin
                    if (scl_rise) begin
                        sr_nxt  = rx_byte;
                        cnt_nxt = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_nxt = '0;
                            case (state)
                                S_DEV_ADDR: begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        rw_nxt    = rx_byte[0];
                                        state_nxt = S_ACK_DEV;
                                    end else begin
                                        state_nxt = S_IDLE;
                                    end
                                end
                                S_ADDR_HI: begin
                                    addr_hi_nxt = rx_byte;
                                    state_nxt   = S_ACK_HI;
                                end
                                S_ADDR_LO: begin
                                    ptr_nxt   = {addr_hi, rx_byte};
                                    state_nxt = S_ACK_LO;
                                end
                                default: begin
                                    mem_we       = 1'b1;
                                    wr_pulse_nxt = 1'b1;
                                    wr_addr_nxt  = ptr;
                                    wr_byte_nxt  = rx_byte;
                                    ptr_nxt      = ptr_inc;
                                    state_nxt    = S_ACK_WR;
                                end
                            endcase
                        end
                    end
                end

                // First fall after the byte pulls sda; the following fall releases it.
                S_ACK_DEV, S_ACK_HI, S_ACK_LO, S_ACK_WR: begin
                    if (scl_fall) begin
                        ack_hold_nxt = ~ack_hold;
                        sda_oe_nxt   = ~ack_hold;
                        if (ack_hold) begin
                            cnt_nxt = '0;
                            case (state)
                                S_ACK_DEV: begin
                                    if (rw) begin
                                        sr_nxt     = {rd_cur[6:0], 1'b0};
                                        sda_oe_nxt = ~rd_cur[7];
                                        cnt_nxt    = 4'd1;
                                        state_nxt  = S_RD_DATA;
                                    end else begin
                                        state_nxt = S_ADDR_HI;
                                    end
                                end
                                S_ACK_HI: state_nxt = S_ADDR_LO;
                                default:  state_nxt = S_WR_DATA;
                            endcase
                        end
                    end
                end

                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = S_RD_ACK;
                        end else begin
                            sda_oe_nxt = ~sr[7];
                            sr_nxt     = {sr[6:0], 1'b0};
                            cnt_nxt    = cnt + 4'd1;
                        end
                    end
                end

                S_RD_ACK: begin
                    if (scl_rise) begin
                        ptr_nxt = ptr_inc;
                        if (!sda_sync) begin
                            sr_nxt    = rd_next;
                            cnt_nxt   = '0;
                            state_nxt = S_RD_DATA;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Scoreboard bench for i2c_eeprom_slave: a bit-banged master drives frames while
// a byte-array/pointer reference model predicts ACKs, read data and write strobes.
module tb_i2c_eeprom_slave;

    localparam logic [6:0]  DEV   = 7'h50;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned Q     = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl   = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_bus;
    logic        sda_oe;
    logic        busy;
    logic        wr_pulse;
    logic [15:0] wr_addr;
    logic [7:0]  wr_byte;

    assign sda_bus = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_eeprom_slave #(
        .DEV_ADDR(DEV),
        .MEM_AW  (AW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl     (scl),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .wr_pulse(wr_pulse),
        .wr_addr (wr_addr),
        .wr_byte (wr_byte)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        bit         is_data;
        logic [7:0] val;
        bit         known;
    } rx_t;

    wr_t exp_wr_q[$];
    rx_t exp_rx_q[$];
    rx_t obs_rx_q[$];

    logic [7:0]  mdl_mem   [DEPTH];
    bit          mdl_known [DEPTH];
    logic [15:0] mdl_ptr = '0;
    logic [15:0] written_q[$];
    logic [7:0]  tx_q[$];
    bit          watch_oe = 1'b0;
    int          oe_seen  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : wr_mon
        wr_t e;
        if (rst_n && wr_pulse) begin
            if (exp_wr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_wr_pulse: got addr 0x%0h byte 0x%0h, expected no write", wr_addr, wr_byte);
            end else begin
                e = exp_wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_byte", 32'(wr_byte), 32'(e.data));
            end
        end
    end

    always @(negedge clk) begin : rx_mon
        rx_t o;
        rx_t e;
        while (obs_rx_q.size() > 0) begin
            o = obs_rx_q.pop_front();
            if (exp_rx_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rx: got 0x%0h, expected nothing", o.val);
            end else begin
                e = exp_rx_q.pop_front();
                if (e.known) begin
                    check(e.is_data ? "rd_byte" : "slave_ack", 32'(o.val), 32'(e.val));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (watch_oe && sda_oe) oe_seen++;
    end

    // Reference model: 16-bit wrapping pointer over an array indexed by its low bits.
    function automatic logic [AW-1:0] mdl_idx(input logic [15:0] a);
        return a[AW-1:0];
    endfunction

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_out(input logic b);
        m_sda = b;
        qwait();
        scl = 1'b1;
        qwait();
        qwait();
        scl = 1'b0;
        qwait();
    endtask

    task automatic bit_in(output logic b);
        m_sda = 1'b1;
        qwait();
        scl = 1'b1;
        qwait();
        b = sda_bus;
        qwait();
        scl = 1'b0;
        qwait();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        qwait();
        scl = 1'b1;
        qwait();
        m_sda = 1'b0;
        qwait();
        scl = 1'b0;
        qwait();
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        qwait();
        scl = 1'b1;
        qwait();
        m_sda = 1'b1;
        qwait();
        qwait();
        check("busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_ack);
        rx_t  e;
        logic a;
        e.is_data = 1'b0;
        e.val     = expect_ack ? 8'd0 : 8'd1;
        e.known   = 1'b1;
        exp_rx_q.push_back(e);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_in(a);
        e.val = {7'd0, a};
        obs_rx_q.push_back(e);
    endtask

    task automatic recv_byte(input bit last);
        rx_t        e;
        logic [7:0] d;
        logic       b;
        e.is_data = 1'b1;
        e.val     = mdl_mem[mdl_idx(mdl_ptr)];
        e.known   = mdl_known[mdl_idx(mdl_ptr)];
        exp_rx_q.push_back(e);
        mdl_ptr = mdl_ptr + 16'd1;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            bit_in(b);
            d = {d[6:0], b};
        end
        bit_out(last);
        e.val   = d;
        e.known = 1'b1;
        obs_rx_q.push_back(e);
    endtask

    task automatic seek(input logic [15:0] a);
        i2c_start();
        send_byte({DEV, 1'b0}, 1'b1);
        send_byte(a[15:8], 1'b1);
        send_byte(a[7:0], 1'b1);
        mdl_ptr = a;
    endtask

    task automatic do_write(input logic [15:0] a);
        seek(a);
        foreach (tx_q[i]) begin
            wr_t w;
            w.addr = mdl_ptr;
            w.data = tx_q[i];
            exp_wr_q.push_back(w);
            mdl_mem[mdl_idx(mdl_ptr)]   = tx_q[i];
            mdl_known[mdl_idx(mdl_ptr)] = 1'b1;
            written_q.push_back(mdl_ptr);
            mdl_ptr = mdl_ptr + 16'd1;
            send_byte(tx_q[i], 1'b1);
        end
        i2c_stop();
    endtask

    task automatic do_read(input bit with_seek, input logic [15:0] a, input int n);
        if (with_seek) seek(a);
        i2c_start();
        send_byte({DEV, 1'b1}, 1'b1);
        for (int i = 0; i < n; i++) recv_byte(i == n - 1);
        i2c_stop();
    endtask

    task automatic foreign_frame(input logic [6:0] addr, input logic rw_bit, input logic [7:0] extra);
        watch_oe = 1'b1;
        oe_seen  = 0;
        i2c_start();
        send_byte({addr, rw_bit}, 1'b0);
        send_byte(extra, 1'b0);
        i2c_stop();
        watch_oe = 1'b0;
        check("foreign_sda_oe_count", 32'(oe_seen), 32'd0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge clk);
        check("rst_sda_oe",   32'(sda_oe),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        check("rst_wr_addr",  32'(wr_addr),  32'd0);
        check("rst_wr_byte",  32'(wr_byte),  32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        tx_q = '{8'h36};
        do_write(16'h0123);
        tx_q = '{8'h5A, 8'h6B};
        do_write(16'h0002);
        do_read(1'b1, 16'h0123, 1);

        tx_q = '{8'h11, 8'h22, 8'h33};
        do_write(16'hFFFF);
        do_read(1'b1, 16'hFFFF, 3);
        do_read(1'b0, 16'h0000, 1);

        watch_oe = 1'b1;
        oe_seen  = 0;
        i2c_start();
        send_byte(8'hA2, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h77, 1'b0);
        i2c_stop();
        watch_oe = 1'b0;
        check("mismatch_sda_oe_count", 32'(oe_seen), 32'd0);

        i2c_start();
        send_byte({DEV, 1'b0}, 1'b1);
        send_byte(8'h40, 1'b1);
        i2c_stop();
        do_read(1'b0, 16'h0000, 1);

        seek(16'h0123);
        i2c_start();
        send_byte({DEV, 1'b1}, 1'b1);
        check("rd_msb_driven", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_sda_oe", 32'(sda_oe), 32'd0);
        check("async_rst_busy",   32'(busy),   32'd0);
        mdl_ptr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        i2c_stop();
        do_read(1'b0, 16'h0000, 1);

        for (int it = 0; it < 14; it++) begin
            int unsigned op;
            int unsigned n;
            logic [6:0]  bad;
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    tx_q.delete();
                    n = $urandom_range(1, 3);
                    for (int k = 0; k < int'(n); k++) tx_q.push_back(8'($urandom));
                    do_write(16'($urandom));
                end
                1: begin
                    do_read(1'b1, written_q[$urandom_range(0, written_q.size() - 1)],
                            int'($urandom_range(1, 3)));
                end
                2: begin
                    do_read(1'b0, 16'h0000, int'($urandom_range(1, 2)));
                end
                default: begin
                    bad = 7'($urandom);
                    if (bad == DEV) bad = bad ^ 7'h01;
                    foreign_frame(bad, 1'($urandom), 8'($urandom));
                end
            endcase
        end

        repeat (20) @(negedge clk);
        check("exp_wr_drained", 32'(exp_wr_q.size()), 32'd0);
        check("exp_rx_drained", 32'(exp_rx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
Synthesizable I2C responder that models a 24-series EEPROM with 16-bit word addressing. It lets the byte read/write master path be exercised end to end in simulation and on board, with no external EEPROM fitted. It sits on the same scl/sda pair driven by the master. It supports byte/sequential write, random read, current-address read and sequential read, all from an internal byte array.

Parameters:
DEV_ADDR, 7'b1010_000, 7-bit slave address; frames to any other address are not acknowledged.
MEM_AW, 8, internal array index width; depth = 2**MEM_AW bytes; array index = low MEM_AW bits of the 16-bit address pointer.

Ports:
clk  input  1  system clock; must be at least 8x the scl frequency.
rst_n  input  1  asynchronous active-low reset.
scl  input  1  I2C clock from master (never driven by this block).
sda_in  input  1  sampled level of the sda line.
sda_oe  output  1  1 = pull sda low; 0 = release (tri-state done at top level).
busy  output  1  high from a detected START to the next STOP.
wr_pulse  output  1  one-clk strobe per byte written into the array.
wr_addr  output  16  full address pointer used for that write; valid with wr_pulse.
wr_byte  output  8  data byte written; valid with wr_pulse.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - sda_oe=0, busy=0, wr_pulse=0, wr_addr=0, wr_byte=0.
  - Address pointer = 0, state = IDLE.
  - Array contents are not reset.
  - Reset mid-frame aborts immediately with sda released.
- Input sampling:
  - scl and sda_in each pass through a 2-flop synchronizer, plus one history flop.
  - All edge detection uses the synchronized signals. Latency from pin to edge detect is 3 clk.
- Bus conditions:
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - START, including repeated START, in any state: go to DEV_ADDR, clear the bit counter, set busy.
  - STOP in any state: go to IDLE, release sda, clear busy.
- Timing rules:
  - Data bits are sampled on the scl rising edge, MSB first.
  - sda_oe changes only on the scl falling edge (1 clk after it is detected).
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift in 8 bits.
    - On 8th rise: if bits[7:1]==DEV_ADDR, latch R/W and go to ACK_DEV. Otherwise go to IDLE and ignore the bus until the next START.
  - ACK_DEV:
    - Drive sda_oe=1 on the next fall; release on the fall after.
    - R/W=0: go to ADDR_HI.
    - R/W=1: go to RD_DATA. Load array[pointer] into the shift register and drive its MSB on that same release fall.
  - ADDR_HI / ACK_HI, then ADDR_LO / ACK_LO:
    - Receive the pointer high byte, then the low byte; ACK each as in ACK_DEV.
    - The pointer loads after the low byte; then go to WR_DATA.
  - WR_DATA: shift in 8 bits. On the 8th rise:
    - write array[pointer[MEM_AW-1:0]];
    - pulse wr_pulse for 1 clk, with wr_addr = pointer and wr_byte = the received byte;
    - increment pointer; go to ACK_WR.
  - ACK_WR: ACK as above, then return to WR_DATA (sequential write). Master ends the write with STOP.
  - RD_DATA: present each later bit on each scl fall. After the 8th bit, release sda on the next fall and go to RD_ACK.
  - RD_ACK: sample sda on the rise.
    - 0 (ACK): increment pointer, load the next byte, go to RD_DATA.
    - 1 (NACK): increment pointer, go to IDLE holding sda released until STOP or START.
- Pointer arithmetic:
  - 16-bit, wraps 16'hFFFF -> 16'h0000.
  - The array index wraps naturally at 2**MEM_AW.
  - The pointer persists across frames, so a current-address read continues from the last access + 1.
- Random read: a write header (device, ADDR_HI, ADDR_LO), then a repeated START with R/W=1 before any data byte. The pointer is already loaded, so the read returns array[new pointer].
- Write timing: no internal write-cycle busy time; the slave ACKs its own address immediately after a write STOP.
- Simultaneous events: a START or STOP detected in the same clk as a data edge takes priority over the data edge.

Test Plan:
- Byte write: START, 0xA0, 0x01, 0x23, 0x36, STOP -> four ACKs; one wr_pulse with wr_addr=16'h0123 and wr_byte=8'h36; busy falls at STOP.
- Random read: write header to 0x0123, repeated START, 0xA1, master NACK, STOP -> slave shifts out 8'h36, sda released after the 8th bit, no wr_pulse.
- Sequential write/read across wrap: write 0x11, 0x22, 0x33 starting at 0xFFFF -> wr_addr sequence 0xFFFF, 0x0000, 0x0001. A read from 0xFFFF with ACK, ACK, NACK returns 0x11, 0x22, 0x33.
- Current-address read: after the previous read, send 0xA1 directly -> returns the byte at pointer 0x0002.
- Address mismatch: send 0xA2 (address 0x51) -> sda_oe stays 0 for the whole frame, no wr_pulse, and the next valid frame still works.
- Abort cases:
  - STOP after ADDR_HI -> IDLE, no write, pointer unchanged.
  - rst_n asserted mid-RD_DATA -> sda_oe=0 asynchronously, pointer=0.
